// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if -- bus between the EX stage and the multiply/divide sequencer.
//   start/op/a/b : launch an operation (MULT/MULTU/DIV/DIVU) with its operands
//   mthi/mtlo    : direct writes of wdata into HI/LO
//   hi/lo        : architectural HI/LO registers
//   busy/done    : sequencer occupancy and one-cycle completion pulse
// master = EX stage / testbench side, slave = sequencer side.
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, op, a, b, mthi, mtlo, wdata,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, a, b, mthi, mtlo, wdata,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq -- iterative radix-2 multiply/divide sequencer owning HI/LO.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : muldiv_seq_if.slave (start/op/a/b in, mthi/mtlo/wdata in,
//                hi/lo/busy/done out)
// Operations run on operand magnitudes over WIDTH cycles (CALC), followed
// by one sign-fixup cycle (FIX) that writes HI/LO and pulses done.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    muldiv_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             state_r;
    logic [CW-1:0]      count_r;
    logic               isDiv_r;
    logic               negResult_r;
    logic               negRem_r;
    logic               divZero_r;
    logic [WIDTH-1:0]   divisor_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               busy_r;
    logic               done_r;

    logic               signedOp_s;
    logic               aNeg_s;
    logic               bNeg_s;
    logic [WIDTH-1:0]   magA_s;
    logic [WIDTH-1:0]   magB_s;
    logic [WIDTH:0]     mulSum_s;
    logic [WIDTH:0]     remShift_s;
    logic [WIDTH-1:0]   remSub_s;
    logic               noBorrow_s;
    logic [2*WIDTH-1:0] accNext_s;
    logic [2*WIDTH-1:0] prodFix_s;
    logic [WIDTH-1:0]   quoFix_s;
    logic [WIDTH-1:0]   remFix_s;

    // Operand sign capture and magnitude conversion at launch.
    always_comb begin
        signedOp_s = ~bus.op[0];
        aNeg_s     = signedOp_s & bus.a[WIDTH-1];
        bNeg_s     = signedOp_s & bus.b[WIDTH-1];
        if (aNeg_s) begin
            magA_s = -bus.a;
        end else begin
            magA_s = bus.a;
        end
        if (bNeg_s) begin
            magB_s = -bus.b;
        end else begin
            magB_s = bus.b;
        end
    end

    // One radix-2 iteration: shift-add for multiply, restoring step for divide.
    // acc_r holds {upper, lower}: for multiply {partial product, multiplier},
    // for divide {remainder, dividend/quotient}.
    always_comb begin
        mulSum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                   + (acc_r[0] ? {1'b0, divisor_r} : {(WIDTH+1){1'b0}});
        remShift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
        noBorrow_s = (remShift_s >= {1'b0, divisor_r});
        // When there is no borrow the true difference is below the divisor,
        // so WIDTH-bit modular subtraction is exact.
        remSub_s   = remShift_s[WIDTH-1:0] - divisor_r;
        if (isDiv_r) begin
            if (noBorrow_s) begin
                accNext_s = {remSub_s, acc_r[WIDTH-2:0], 1'b1};
            end else begin
                accNext_s = {remShift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            accNext_s = {mulSum_s, acc_r[WIDTH-1:1]};
        end
    end

    // Sign fixup of the finished magnitude result.
    always_comb begin
        if (negResult_r) begin
            prodFix_s = -acc_r;
        end else begin
            prodFix_s = acc_r;
        end
        // Divide by zero leaves all quotient bits set; force LO to all ones
        // regardless of sign. The remainder equals |a|, so restoring the sign
        // of a returns the original a in HI.
        if (divZero_r) begin
            quoFix_s = {WIDTH{1'b1}};
        end else if (negResult_r) begin
            quoFix_s = -acc_r[WIDTH-1:0];
        end else begin
            quoFix_s = acc_r[WIDTH-1:0];
        end
        if (negRem_r) begin
            remFix_s = -acc_r[2*WIDTH-1:WIDTH];
        end else begin
            remFix_s = acc_r[2*WIDTH-1:WIDTH];
        end
    end

    // Sequencer FSM, datapath registers and HI/LO ownership.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            count_r     <= {CW{1'b0}};
            isDiv_r     <= 1'b0;
            negResult_r <= 1'b0;
            negRem_r    <= 1'b0;
            divZero_r   <= 1'b0;
            divisor_r   <= {WIDTH{1'b0}};
            acc_r       <= {(2*WIDTH){1'b0}};
            hi_r        <= {WIDTH{1'b0}};
            lo_r        <= {WIDTH{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        // Multiply is commutative, so both operation classes
                        // load a into the lower accumulator word and b into
                        // the addend/divisor register.
                        isDiv_r     <= bus.op[1];
                        negResult_r <= aNeg_s ^ bNeg_s;
                        negRem_r    <= aNeg_s;
                        divZero_r   <= (bus.b == {WIDTH{1'b0}});
                        divisor_r   <= magB_s;
                        acc_r       <= {{WIDTH{1'b0}}, magA_s};
                        count_r     <= CW'(WIDTH);
                        busy_r      <= 1'b1;
                        state_r     <= CALC;
                    end else begin
                        if (bus.mthi) begin
                            hi_r <= bus.wdata;
                        end
                        if (bus.mtlo) begin
                            lo_r <= bus.wdata;
                        end
                    end
                end
                CALC: begin
                    acc_r   <= accNext_s;
                    count_r <= count_r - CW'(1);
                    if (count_r == CW'(1)) begin
                        state_r <= FIX;
                    end
                end
                FIX: begin
                    if (isDiv_r) begin
                        hi_r <= remFix_s;
                        lo_r <= quoFix_s;
                    end else begin
                        hi_r <= prodFix_s[2*WIDTH-1:WIDTH];
                        lo_r <= prodFix_s[WIDTH-1:0];
                    end
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq -- self-checking bench for muldiv_seq with a plain-arithmetic
// reference model of MULT/MULTU/DIV/DIVU and of HI/LO contents.
module tb_muldiv_seq;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    muldiv_seq_if #(.WIDTH(W)) bus();

    muldiv_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int nCompared   = 0;
    int nMismatched = 0;
    logic [31:0] expHi = 32'h0;
    logic [31:0] expLo = 32'h0;

    // Reference model: architectural results from plain arithmetic.
    function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] h, output logic [31:0] l);
        longint      ps;
        logic [63:0] pu;
        case (o)
            2'd0: begin
                ps = longint'($signed(x)) * longint'($signed(y));
                {h, l} = ps;
            end
            2'd1: begin
                pu = {32'h0, x} * {32'h0, y};
                {h, l} = pu;
            end
            2'd2: begin
                if (y == 32'h0) begin
                    l = 32'hFFFF_FFFF; h = x;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    l = 32'h8000_0000; h = 32'h0;
                end else begin
                    l = $signed(x) / $signed(y);
                    h = $signed(x) % $signed(y);
                end
            end
            default: begin
                if (y == 32'h0) begin
                    l = 32'hFFFF_FFFF; h = x;
                end else begin
                    l = x / y;
                    h = x % y;
                end
            end
        endcase
    endfunction

    // Launch one operation (called at a negedge) and wait for done.
    // lat = posedges from acceptance to the done cycle, -1 on timeout.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit noisy, output int lat, output int busyCnt,
                          output logic busyAtDone);
        bit got;
        got = 1'b0;
        bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
        if (noisy) begin
            bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'h0000_1234;
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
        lat = 0; busyCnt = 0; busyAtDone = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                got = 1'b1;
                busyAtDone = bus.busy;
                break;
            end
            if (bus.busy === 1'b1) busyCnt++;
            if (noisy && lat == 10) begin
                bus.start = 1'b1; bus.mthi = 1'b1; bus.op = 2'd0;
                bus.a = $urandom; bus.b = $urandom; bus.wdata = $urandom;
            end
            @(posedge clk);
            lat++;
            #1;
            bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
        end
        if (!got) lat = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0; bus.op = 2'd0; bus.a = 32'h0; bus.b = 32'h0;
        bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = 32'h0;
        #3;
        nCompared++; if (bus.hi !== 32'h0) begin nMismatched++; $display("FAIL reset_hi: got %h want 0", bus.hi); end
        nCompared++; if (bus.lo !== 32'h0) begin nMismatched++; $display("FAIL reset_lo: got %h want 0", bus.lo); end
        nCompared++; if (bus.busy !== 1'b0) begin nMismatched++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        nCompared++; if (bus.done !== 1'b0) begin nMismatched++; $display("FAIL reset_done: got %b want 0", bus.done); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_multu_max();
        int lat, bc; logic bd;
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, bc, bd);
        expHi = 32'hFFFF_FFFE; expLo = 32'h0000_0001;
        nCompared++; if (lat !== 33) begin nMismatched++; $display("FAIL multu_latency: got %0d want 33", lat); end
        nCompared++; if (bc !== 33) begin nMismatched++; $display("FAIL multu_busy_cycles: got %0d want 33", bc); end
        nCompared++; if (bd !== 1'b0) begin nMismatched++; $display("FAIL multu_busy_in_done: got %b want 0", bd); end
        nCompared++; if (bus.hi !== expHi) begin nMismatched++; $display("FAIL multu_hi: got %h want %h", bus.hi, expHi); end
        nCompared++; if (bus.lo !== expLo) begin nMismatched++; $display("FAIL multu_lo: got %h want %h", bus.lo, expLo); end
        @(negedge clk);
        nCompared++; if (bus.done !== 1'b0) begin nMismatched++; $display("FAIL done_one_cycle: got %b want 0", bus.done); end
    endtask

    task automatic test_signed();
        int lat, bc; logic bd;
        run_op(2'd0, 32'hFFFF_FFFD, 32'd5, 1'b0, lat, bc, bd);
        nCompared++; if (bus.hi !== 32'hFFFF_FFFF) begin nMismatched++; $display("FAIL mult_hi: got %h want ffffffff", bus.hi); end
        nCompared++; if (bus.lo !== 32'hFFFF_FFF1) begin nMismatched++; $display("FAIL mult_lo: got %h want fffffff1", bus.lo); end
        @(negedge clk);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, lat, bc, bd);
        expHi = 32'hFFFF_FFFF; expLo = 32'hFFFF_FFFD;
        nCompared++; if (bus.lo !== expLo) begin nMismatched++; $display("FAIL div_lo: got %h want %h", bus.lo, expLo); end
        nCompared++; if (bus.hi !== expHi) begin nMismatched++; $display("FAIL div_hi: got %h want %h", bus.hi, expHi); end
        nCompared++; if (lat !== 33) begin nMismatched++; $display("FAIL div_latency: got %0d want 33", lat); end
    endtask

    task automatic test_div_special();
        int lat, bc; logic bd;
        @(negedge clk);
        run_op(2'd3, 32'd100, 32'd0, 1'b0, lat, bc, bd);
        nCompared++; if (bus.lo !== 32'hFFFF_FFFF) begin nMismatched++; $display("FAIL divu0_lo: got %h want ffffffff", bus.lo); end
        nCompared++; if (bus.hi !== 32'h0000_0064) begin nMismatched++; $display("FAIL divu0_hi: got %h want 00000064", bus.hi); end
        nCompared++; if (lat !== 33) begin nMismatched++; $display("FAIL divu0_latency: got %0d want 33", lat); end
        @(negedge clk);
        run_op(2'd2, 32'hFFFF_FFF0, 32'd0, 1'b0, lat, bc, bd);
        nCompared++; if (bus.lo !== 32'hFFFF_FFFF) begin nMismatched++; $display("FAIL div0_neg_lo: got %h want ffffffff", bus.lo); end
        nCompared++; if (bus.hi !== 32'hFFFF_FFF0) begin nMismatched++; $display("FAIL div0_neg_hi: got %h want fffffff0", bus.hi); end
        @(negedge clk);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, bc, bd);
        expHi = 32'h0; expLo = 32'h8000_0000;
        nCompared++; if (bus.lo !== expLo) begin nMismatched++; $display("FAIL div_ovf_lo: got %h want %h", bus.lo, expLo); end
        nCompared++; if (bus.hi !== expHi) begin nMismatched++; $display("FAIL div_ovf_hi: got %h want %h", bus.hi, expHi); end
    endtask

    task automatic test_mt_idle();
        logic [31:0] v;
        @(negedge clk);
        bus.mthi = 1'b1; bus.wdata = 32'hAAAA_5555;
        #1;
        nCompared++; if (bus.hi !== expHi) begin nMismatched++; $display("FAIL mthi_before_edge: got %h want %h", bus.hi, expHi); end
        @(posedge clk); #1 bus.mthi = 1'b0;
        expHi = 32'hAAAA_5555;
        nCompared++; if (bus.hi !== expHi) begin nMismatched++; $display("FAIL mthi: got %h want %h", bus.hi, expHi); end
        nCompared++; if (bus.lo !== expLo) begin nMismatched++; $display("FAIL mthi_lo_kept: got %h want %h", bus.lo, expLo); end
        @(negedge clk);
        bus.mtlo = 1'b1; bus.wdata = 32'h0F0F_0F0F;
        @(posedge clk); #1 bus.mtlo = 1'b0;
        expLo = 32'h0F0F_0F0F;
        nCompared++; if (bus.lo !== expLo) begin nMismatched++; $display("FAIL mtlo: got %h want %h", bus.lo, expLo); end
        nCompared++; if (bus.hi !== expHi) begin nMismatched++; $display("FAIL mtlo_hi_kept: got %h want %h", bus.hi, expHi); end
        @(negedge clk);
        v = $urandom;
        bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = v;
        @(posedge clk); #1 bus.mthi = 1'b0; bus.mtlo = 1'b0;
        expHi = v; expLo = v;
        nCompared++; if (bus.hi !== expHi || bus.lo !== expLo) begin nMismatched++; $display("FAIL mt_both: got %h/%h want %h/%h", bus.hi, bus.lo, expHi, expLo); end
    endtask

    task automatic test_mt_ignored();
        int lat, bc; logic bd;
        @(negedge clk);
        run_op(2'd3, 32'd10, 32'd3, 1'b1, lat, bc, bd);
        expHi = 32'd1; expLo = 32'd3;
        nCompared++; if (lat !== 33) begin nMismatched++; $display("FAIL mt_ign_latency: got %0d want 33", lat); end
        nCompared++; if (bus.hi !== expHi) begin nMismatched++; $display("FAIL mt_ign_hi: got %h want %h", bus.hi, expHi); end
        nCompared++; if (bus.lo !== expLo) begin nMismatched++; $display("FAIL mt_ign_lo: got %h want %h", bus.lo, expLo); end
        @(negedge clk);
        nCompared++; if (bus.busy !== 1'b0 || bus.hi !== expHi) begin nMismatched++; $display("FAIL mt_ign_idle_after: busy %b hi %h want 0 %h", bus.busy, bus.hi, expHi); end
    endtask

    task automatic test_back_to_back();
        int lat, bc; logic bd;
        logic [1:0] o; logic [31:0] x, y, h, l;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            o = 2'(i); x = $urandom; y = $urandom_range(1, 1000);
            model(o, x, y, h, l);
            run_op(o, x, y, 1'b0, lat, bc, bd);
            expHi = h; expLo = l;
            nCompared++; if (lat !== 33) begin nMismatched++; $display("FAIL b2b_latency[%0d]: got %0d want 33", i, lat); end
            nCompared++; if (bus.hi !== h || bus.lo !== l) begin nMismatched++; $display("FAIL b2b_result[%0d]: got %h/%h want %h/%h", i, bus.hi, bus.lo, h, l); end
        end
    endtask

    task automatic test_random();
        int lat, bc; logic bd;
        logic [1:0] o; logic [31:0] x, y, h, l;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            x = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 4))
                0:       y = 32'h0;
                1:       y = 32'($urandom_range(1, 7));
                2:       y = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: y = $urandom;
            endcase
            model(o, x, y, h, l);
            @(negedge clk);
            run_op(o, x, y, 1'b0, lat, bc, bd);
            expHi = h; expLo = l;
            nCompared++; if (bus.hi !== h || bus.lo !== l || lat !== 33) begin nMismatched++; $display("FAIL rand[%0d] op%0d %h,%h: got %h/%h lat %0d want %h/%h lat 33", i, o, x, y, bus.hi, bus.lo, lat, h, l); end
        end
    endtask

    task automatic test_async_reset();
        int lat, bc; logic bd;
        bit sawDone;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'd0; bus.a = 32'hFFFF_FFFD; bus.b = 32'd5;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        expHi = 32'h0; expLo = 32'h0;
        nCompared++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin nMismatched++; $display("FAIL arst_hilo: got %h/%h want 0/0", bus.hi, bus.lo); end
        nCompared++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin nMismatched++; $display("FAIL arst_busy_done: got %b/%b want 0/0", bus.busy, bus.done); end
        @(negedge clk);
        rst_n = 1'b1;
        sawDone = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) sawDone = 1'b1;
        end
        nCompared++; if (sawDone !== 1'b0) begin nMismatched++; $display("FAIL arst_no_done: got activity %b want 0", sawDone); end
        nCompared++; if (bus.hi !== expHi || bus.lo !== expLo) begin nMismatched++; $display("FAIL arst_hilo_kept: got %h/%h want 0/0", bus.hi, bus.lo); end
        run_op(2'd1, 32'd123456, 32'd789, 1'b0, lat, bc, bd);
        nCompared++; if (lat !== 33 || bus.lo !== 32'd97406784 || bus.hi !== 32'h0) begin nMismatched++; $display("FAIL arst_next_op: got %h/%h lat %0d want 0/%h lat 33", bus.hi, bus.lo, lat, 32'd97406784); end
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_signed();
        test_div_special();
        test_mt_idle();
        test_mt_ignored();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
